// File: rtl/hi_lo_unit_if.sv
// HI/LO engine <-> execute stage bundle: op issue, MFHI/MFLO read, stall/status.
// Latency: n/a (wiring only).
// Backpressure: stall is driven by the engine; the execute stage holds its op while it is high.
interface hi_lo_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mfhi_ex;
  logic        mflo_ex;
  logic [31:0] hi_lo_out;
  logic        busy;
  logic        stall;
  logic        div_zero;

  // Execute stage side
  modport master (
    output start, op, rs_val, rt_val, mfhi_ex, mflo_ex,
    input  hi_lo_out, busy, stall, div_zero
  );

  // Engine side
  modport slave (
    input  start, op, rs_val, rt_val, mfhi_ex, mflo_ex,
    output hi_lo_out, busy, stall, div_zero
  );
endinterface

// File: rtl/hi_lo_unit.sv
// Iterative 32-step mult/div engine owning the architectural HI/LO registers.
// Latency: MULT/DIV 33 busy cycles after acceptance, result readable the cycle after; MTHI/MTLO 1 cycle.
// Backpressure: while busy, any start or MFHI/MFLO raises stall and is not accepted.
module hi_lo_unit (
  input logic         clk,
  input logic         reset_n,
  hi_lo_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;        // {acc, multiplier} or {remainder, quotient}
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q_q, neg_q_d;    // product / quotient sign
  logic        neg_r_q, neg_r_d;    // remainder sign
  logic        dz_q, dz_d;          // current divide has a zero divisor
  logic [31:0] src_q, src_d;        // raw rs, returned as HI on divide by zero
  logic        div_zero_q, div_zero_d;

  // Operand decode for a newly presented op
  logic        md_op;
  logic        div_op;
  logic        signed_op;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic        accept_md;

  assign md_op     = (bus.op[2] == 1'b0);
  assign div_op    = md_op & bus.op[1];
  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign rs_neg    = signed_op & bus.rs_val[31];
  assign rt_neg    = signed_op & bus.rt_val[31];
  assign rs_mag    = rs_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
  assign rt_mag    = rt_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
  assign accept_md = (state_q == ST_IDLE) & bus.start & md_op;

  // Multiply step: conditionally add multiplicand to the upper half, then shift right
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide step: shift left, trial-subtract, keep result if no borrow
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        q_bit;
  logic [63:0] div_next;
  assign rem_sh   = acc_q[63:31];
  assign trial    = rem_sh - {1'b0, opnd_q};
  assign q_bit    = ~trial[32];
  assign div_next = {(q_bit ? trial[31:0] : rem_sh[31:0]), acc_q[30:0], q_bit};

  // Result correction applied in FIX
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  assign prod_fix = neg_q_q ? (64'd0 - acc_q) : acc_q;
  assign quot_fix = neg_q_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  // Next-state logic for the FSM, datapath and HI/LO
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    dz_d       = dz_q;
    src_d      = src_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_md) begin
          state_d    = ST_CALC;
          cnt_d      = 5'd0;
          is_div_d   = div_op;
          neg_q_d    = rs_neg ^ rt_neg;
          neg_r_d    = rs_neg;
          dz_d       = div_op & (bus.rt_val == 32'd0);
          div_zero_d = div_op & (bus.rt_val == 32'd0);
          src_d      = bus.rs_val;
          opnd_d     = div_op ? rt_mag : rs_mag;
          acc_d      = {32'd0, (div_op ? rs_mag : rt_mag)};
        end else if (bus.start && bus.op == OP_MTHI) begin
          hi_d = bus.rs_val;
        end else if (bus.start && bus.op == OP_MTLO) begin
          lo_d = bus.rs_val;
        end
      end
      ST_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == 5'd31) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          hi_d = src_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 64'd0;
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      src_q      <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      dz_q       <= dz_d;
      src_q      <= src_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.stall     = bus.busy & (bus.start | bus.mfhi_ex | bus.mflo_ex);
  assign bus.hi_lo_out = bus.mfhi_ex ? hi_q : lo_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: doc/hi_lo_unit.md
# hi_lo_unit

Multi-cycle multiply/divide engine holding the architectural HI and LO registers for one core of the dual-core MIPS processor. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs an iterative 32-step shift-add multiplier or restoring divider. It supplies the HI/LO value that travels down the pipeline as `hi_lo_wb` for MFHI/MFLO, and stalls the pipeline while a result is pending.

## Interface
- Parameters: none (datapath fixed at 32 bits, 32 iterations).
- `clk` in 1: core clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: execute stage presents a HI/LO-writing op this cycle.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are ignored (no state change).
- `rs_val` in 32: multiplicand / dividend / MTHI-MTLO source.
- `rt_val` in 32: multiplier / divisor.
- `mfhi_ex`, `mflo_ex` in 1: MFHI / MFLO in execute this cycle (mutually exclusive).
- `hi_lo_out` out 32: HI if `mfhi_ex`, else LO (combinational from registers).
- `busy` out 1: engine in CALC or FIX.
- `stall` out 1: `busy & (start | mfhi_ex | mflo_ex)`.
- `div_zero` out 1: sticky flag, set by DIV/DIVU with `rt_val == 0`, cleared by the next accepted MULT/MULTU/DIV/DIVU.

## Operation
- Registers: HI, LO, operand magnitudes, 64-bit accumulator/remainder-quotient, 5-bit iteration count, result-negate flags, state.
- States: IDLE, CALC, FIX.
- IDLE:
  - `start` with MULT/MULTU/DIV/DIVU latches the operands and goes to CALC with count = 0.
  - Signed ops latch absolute values, plus the negate flags: product sign = sign(rs) ^ sign(rt); quotient sign the same; remainder sign = sign(rs).
- CALC: one iteration per cycle. At count = 31 go to FIX, otherwise increment count.
  - Multiply: shift-add on a 64-bit {acc, multiplier} pair.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor, set the quotient bit.
- FIX: apply the negations (64-bit two's complement for the product), write HI/LO, return to IDLE.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: runs the full latency, then writes HI = rs_val (as latched, sign-unmodified) and LO = 32'hFFFFFFFF for both signed and unsigned. `div_zero` is set.
- Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0. This falls out of the magnitude arithmetic and needs no special case.
- MTHI/MTLO:
  - In IDLE, write HI/LO at that edge, single cycle.
  - While busy, they are stalled and not accepted.
- A `start` while busy is not accepted. The pipeline holds it via `stall` until the engine is IDLE.
- Reset (any time, including mid-CALC):
  - HI = LO = 0, state IDLE, count 0, `div_zero` = 0.
  - The in-flight operation is discarded.
  - Outputs after reset: `busy` 0, `stall` 0, `hi_lo_out` 0.

## Timing
- Start accepted at edge E0 goes to CALC. Iterations occur at edges E1..E32, and E32 moves to FIX. HI/LO are written at E33.
- `busy` is high in the cycles after E0 through E33, i.e. 33 cycles.
- MFHI/MFLO issued in the cycle after E33 reads the new value without stall.
- MFHI/MFLO during busy: `stall` is high each such cycle and deasserts in the cycle after E33. `hi_lo_out` is valid in that same cycle.
- MTHI at edge E, followed by MFHI in the next cycle, returns the written value.
- A `start` held under stall is accepted at the first edge with `busy` = 0. Back-to-back ops therefore start every 34 cycles.
- A `start` and `mfhi_ex` in the same IDLE cycle cannot occur (single-issue). If they do, the read sees the old register value.

## Test plan
- Reset mid-CALC (after 10 cycles) -> `busy`, `stall`, HI, LO = 0 immediately, including asynchronously before the next clock edge. No later write occurs.
- MULT rs = 0xFFFFFFFE (-2), rt = 0x00000003 -> after 33 busy cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV rs = -7 (0xFFFFFFF9), rt = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU rs = 100, rt = 7 -> LO = 14, HI = 2.
- DIVU rs = 0x12345678, rt = 0 -> HI = 0x12345678, LO = 0xFFFFFFFF, `div_zero` = 1. A following MULT clears `div_zero`.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- MULT, then MFLO held in execute on the next cycle -> `stall` = 1 for 33 cycles, then `hi_lo_out` = new LO. MTLO 0xCAFEF00D while busy stalls and is written only after completion. A subsequent MFLO returns 0xCAFEF00D.
